// File: rtl/pak_cfg_loader.sv
// pak_cfg_loader: streams config words into the pak-dsp register file, GPR last, with optional read-back verify
module pak_cfg_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 31,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  verify_en,
  input  logic [DATA_WIDTH-1:0] src_data_in,
  input  logic                  src_valid_in,
  output logic                  src_ready_out,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr
);
  typedef enum logic [2:0] {IDLE, LOAD, WR_GPR, RD_ISSUE, RD_DRAIN, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST       = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(RD_LATENCY > 0 ? RD_LATENCY - 1 : 0);
  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    verify_q, rd_vld, hs, em_v;
  logic [ADDR_WIDTH-1:0]   em_a;
  logic [DATA_WIDTH-1:0]   shadow [NUM_REGS];
  // next-state decode; cnt doubles as word, read-address and drain counter
  always_comb begin
    hs = src_ready_out & src_valid_in;
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = LOAD;
      LOAD:     if (hs && cnt == LAST) state_n = WR_GPR;
      WR_GPR:   state_n = verify_q ? RD_ISSUE : DONE;
      RD_ISSUE: if (cnt == LAST) state_n = RD_LATENCY == 0 ? DONE : RD_DRAIN;
      RD_DRAIN: if (cnt == DRAIN_LAST) state_n = DONE;
      default:  state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else state <= state_n;
  end
  // shadow copy of every accepted word, needed for the GPR write and read-back compare
  always_ff @(posedge clk) begin
    if (hs) shadow[cnt] <= src_data_in;
  end
  // registered bus outputs, status flags and counter
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      src_ready_out <= 1'b0;
      addr          <= '0;
      write_en      <= 1'b0;
      wdata         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_addr      <= '0;
      cnt           <= '0;
      verify_q      <= 1'b0;
      rd_vld        <= 1'b0;
    end else begin
      src_ready_out <= state_n == LOAD;
      busy          <= state_n != IDLE;
      done          <= state == DONE;
      write_en      <= 1'b0;
      rd_vld        <= 1'b0;
      if (state == IDLE && start) begin
        verify_q <= verify_en;
        error    <= 1'b0;
        err_addr <= '0;
        cnt      <= '0;
      end
      if (hs) begin
        cnt <= cnt + 1'b1;
        if (cnt != '0) begin
          addr     <= cnt;
          wdata    <= src_data_in;
          write_en <= 1'b1;
        end
      end
      if (state == WR_GPR) begin
        addr     <= '0;
        wdata    <= shadow[0];
        write_en <= 1'b1;
        cnt      <= '0;
      end
      if (state == RD_ISSUE) begin
        addr   <= cnt;
        rd_vld <= 1'b1;
        cnt    <= cnt == LAST ? '0 : cnt + 1'b1;
      end
      if (state == RD_DRAIN) cnt <= cnt + 1'b1;
      if (em_v && !error && rdata != shadow[em_a]) begin
        error    <= 1'b1;
        err_addr <= em_a;
      end
    end
  end
  // read address delay line: the addr register is stage 0, RD_LATENCY more stages follow
  if (RD_LATENCY == 0) begin : g_nolat
    assign em_v = rd_vld;
    assign em_a = addr;
  end else begin : g_lat
    logic [RD_LATENCY-1:0] dv;
    logic [ADDR_WIDTH-1:0] da [RD_LATENCY];
    // shift issued read addresses until their data returns
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        dv <= '0;
        for (int i = 0; i < RD_LATENCY; i++) da[i] <= '0;
      end else begin
        dv[0] <= rd_vld;
        da[0] <= addr;
        for (int i = 1; i < RD_LATENCY; i++) begin
          dv[i] <= dv[i-1];
          da[i] <= da[i-1];
        end
      end
    end
    assign em_v = dv[RD_LATENCY-1];
    assign em_a = da[RD_LATENCY-1];
  end
endmodule

// File: tb/tb_pak_cfg_loader.sv
// tb_pak_cfg_loader: table-driven bench with write scoreboard across RD_LATENCY 0/1/3 builds
module tb_pak_cfg_loader;
  localparam int N = 31;
  typedef struct {
    logic        verify;
    logic        gap;
    logic        corrupt;
    logic        poke;
    logic [15:0] base;
    logic        exp_err;
    logic [4:0]  exp_ea;
    int          exp_done;
  } vec_t;

  logic clk = 1'b0, arst, start, verify_en, src_valid_in, corrupt;
  logic [15:0] src_data_in;
  logic rdy_1, we_1, busy_1, done_1, err_1;
  logic rdy_0, we_0, busy_0, done_0, err_0;
  logic rdy_3, we_3, busy_3, done_3, err_3;
  logic [4:0] addr_1, ea_1, addr_0, ea_0, addr_3, ea_3;
  logic [15:0] wd_1, rd_1, wd_0, rd_0, wd_3, rd_3, p1, p2;
  logic [15:0] rf1 [N];
  logic [15:0] rf0 [N];
  logic [15:0] rf3 [N];
  logic [20:0] q [$];
  int n = 0, fails = 0, cyc = 0, t0, d1, d0, d3;
  logic bd1;
  vec_t tbl [5];

  always #5 clk = ~clk;

  pak_cfg_loader #(.RD_LATENCY(1)) u1 (.clk(clk), .arst(arst), .start(start), .verify_en(verify_en),
    .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(rdy_1), .addr(addr_1),
    .write_en(we_1), .wdata(wd_1), .rdata(rd_1), .busy(busy_1), .done(done_1), .error(err_1), .err_addr(ea_1));
  pak_cfg_loader #(.RD_LATENCY(0)) u0 (.clk(clk), .arst(arst), .start(start), .verify_en(verify_en),
    .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(rdy_0), .addr(addr_0),
    .write_en(we_0), .wdata(wd_0), .rdata(rd_0), .busy(busy_0), .done(done_0), .error(err_0), .err_addr(ea_0));
  pak_cfg_loader #(.RD_LATENCY(3)) u3 (.clk(clk), .arst(arst), .start(start), .verify_en(verify_en),
    .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(rdy_3), .addr(addr_3),
    .write_en(we_3), .wdata(wd_3), .rdata(rd_3), .busy(busy_3), .done(done_3), .error(err_3), .err_addr(ea_3));

  function automatic logic [15:0] rdv(input logic [15:0] v, input logic [4:0] a, input logic c);
    return (c && a == 5'd7) ? 16'hDEAD : (c && a == 5'd12) ? (v ^ 16'h0001) : v;
  endfunction

  always @(posedge clk) begin
    if (we_1) rf1[addr_1] <= wd_1;
    rd_1 <= rdv(rf1[addr_1], addr_1, corrupt);
  end
  always @(posedge clk) if (we_0) rf0[addr_0] <= wd_0;
  always_comb rd_0 = rdv(rf0[addr_0], addr_0, corrupt);
  always @(posedge clk) begin
    if (we_3) rf3[addr_3] <= wd_3;
    p1   <= rdv(rf3[addr_3], addr_3, corrupt);
    p2   <= p1;
    rd_3 <= p2;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (we_1) begin
      if (q.size() == 0) chk("wr_extra", 32'(we_1), 32'd0);
      else chk("wr_bus", {11'd0, addr_1, wd_1}, {11'd0, q.pop_front()});
    end
    if (done_1 && d1 < 0) begin d1 = cyc; bd1 = busy_1; end
    if (done_0 && d0 < 0) d0 = cyc;
    if (done_3 && d3 < 0) d3 = cyc;
  endtask

  task automatic feed(input vec_t v, input int words);
    int i = 0, j = 1;
    while (i < words && j < 400) begin
      src_valid_in = !v.gap || (j % 2 == 1);
      src_data_in  = v.base + 16'(i);
      start        = v.poke && j == 5;
      if (src_valid_in && rdy_1) begin
        if (i > 0) q.push_back({5'(i), v.base + 16'(i)});
        if (i == N - 1) q.push_back({5'd0, v.base});
        i++;
      end
      tick();
      j++;
    end
    src_valid_in = 1'b0;
    start = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int k = 0;
    corrupt = v.corrupt;
    d1 = -1; d0 = -1; d3 = -1; bd1 = 1'b1;
    verify_en = v.verify;
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    chk("ready_after_start", 32'(rdy_1), 32'd1);
    chk("busy_after_start", 32'(busy_1), 32'd1);
    feed(v, N);
    while (d3 < 0 && k < 300) begin tick(); k++; end
    chk("done_l1", d1 - t0, v.exp_done);
    chk("done_l0", d0 - t0, v.exp_done - (v.verify ? 1 : 0));
    chk("done_l3", d3 - t0, v.exp_done + (v.verify ? 2 : 0));
    chk("busy_at_done", 32'(bd1), 32'd0);
    chk("err_l1", {27'd0, err_1, ea_1}, {27'd0, v.exp_err, v.exp_ea});
    chk("err_l0", {27'd0, err_0, ea_0}, {27'd0, v.exp_err, v.exp_ea});
    chk("err_l3", {27'd0, err_3, ea_3}, {27'd0, v.exp_err, v.exp_ea});
    chk("sb_empty", q.size(), 0);
    for (int r = 0; r < N; r++) chk("rf_contents", 32'(rf1[r]), 32'(v.base + 16'(r)));
    tick();
    chk("done_pulse_end", 32'(done_1), 32'd0);
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 5'd0, 33};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 1'b0, 5'd0, 65};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 1'b1, 5'd7, 65};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 5'd0, 63};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 5'd0, 33};
    arst = 1'b1; start = 1'b0; verify_en = 1'b0; src_valid_in = 1'b0; src_data_in = '0; corrupt = 1'b0;
    d1 = -1; d0 = -1; d3 = -1;
    tick(); tick();
    chk("rst_ready", 32'(rdy_1), 32'd0);
    chk("rst_addr", 32'(addr_1), 32'd0);
    chk("rst_we", 32'(we_1), 32'd0);
    chk("rst_wdata", 32'(wd_1), 32'd0);
    chk("rst_busy", 32'(busy_1), 32'd0);
    chk("rst_done", 32'(done_1), 32'd0);
    chk("rst_err", {27'd0, err_1, ea_1}, 32'd0);
    arst = 1'b0;
    tick(); tick();
    chk("idle_busy", 32'(busy_1), 32'd0);
    for (int v = 0; v < 5; v++) run(tbl[v]);
    rv = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h5000, 1'b0, 5'd0, 0};
    verify_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(rv, 11);
    chk("we_before_rst", 32'(we_1), 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(we_1), 32'd0);
    chk("rst_mid_busy", 32'(busy_1), 32'd0);
    chk("rst_mid_ready", 32'(rdy_1), 32'd0);
    chk("rst_mid_we_l3", 32'(we_3), 32'd0);
    tick();
    arst = 1'b0;
    q.delete();
    tick();
    chk("post_rst_busy", 32'(busy_1), 32'd0);
    run(tbl[1]);
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
